// File: rtl/adc_pkg.sv
// Shared constants, state encodings and address-bit helper for the ADC scanner.
package adc_pkg;

    localparam int unsigned FRAME_BITS   = 16;
    localparam int unsigned ADC_BITS     = 12;
    localparam int unsigned ADDR_MSB_BIT = 2;
    localparam int unsigned ADDR_LSB_BIT = 4;
    localparam int unsigned BIT_CNT_W    = $clog2(FRAME_BITS);

    typedef enum logic [1:0] {
        StIdle,
        StGap,
        StShift,
        StStore
    } scan_state_e;

    typedef enum logic {
        PhLowPending,
        PhHighPending
    } sclk_phase_e;

    // Serial address bit for a given frame bit: channel MSB first in bits 2..4, zero elsewhere.
    function automatic logic addr_bit(input logic [2:0] ch, input logic [BIT_CNT_W-1:0] bit_idx);
        logic b;
        b = 1'b0;
        if (bit_idx >= BIT_CNT_W'(ADDR_MSB_BIT) && bit_idx <= BIT_CNT_W'(ADDR_LSB_BIT)) begin
            b = ch[2'(BIT_CNT_W'(ADDR_LSB_BIT) - bit_idx)];
        end
        return b;
    endfunction

endpackage

// File: rtl/depth_averager.sv
// Box-car average of one ADC channel; publishes a zero-extended 12-bit mean per 2^AVG_LOG2 samples.
module depth_averager
    import adc_pkg::*;
#(
    parameter int unsigned DEPTH_CH = 0,
    parameter int unsigned AVG_LOG2 = 4
) (
    input  logic                sys_clk,
    input  logic                reset,
    input  logic                sample_valid,
    input  logic [2:0]          sample_ch,
    input  logic [ADC_BITS-1:0] sample_data,
    output logic [31:0]         raw_depth,
    output logic                depth_valid
);

    localparam int unsigned AccW = ADC_BITS + AVG_LOG2;
    localparam int unsigned CntW = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam logic [CntW-1:0] CntLast = CntW'((1 << AVG_LOG2) - 1);

    logic [AccW-1:0]     acc_q;
    logic [AccW-1:0]     sum;
    logic [CntW-1:0]     avg_cnt_q;
    logic [ADC_BITS-1:0] avg;
    logic [ADC_BITS-1:0] raw_depth_q;
    logic                depth_valid_q;
    logic                hit;

    assign hit = sample_valid && (sample_ch == 3'(DEPTH_CH));
    assign sum = acc_q + AccW'(sample_data);
    // Dividing by 2^AVG_LOG2 is taking the top ADC_BITS of the full-width sum.
    assign avg = sum[AccW-1 -: ADC_BITS];

    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            acc_q         <= '0;
            avg_cnt_q     <= '0;
            raw_depth_q   <= '0;
            depth_valid_q <= 1'b0;
        end else begin
            depth_valid_q <= 1'b0;
            if (hit) begin
                if (avg_cnt_q == CntLast) begin
                    acc_q         <= '0;
                    avg_cnt_q     <= '0;
                    raw_depth_q   <= avg;
                    depth_valid_q <= 1'b1;
                end else begin
                    acc_q     <= sum;
                    avg_cnt_q <= avg_cnt_q + 1'b1;
                end
            end
        end
    end

    assign raw_depth   = {{(32 - ADC_BITS){1'b0}}, raw_depth_q};
    assign depth_valid = depth_valid_q;

endmodule

// File: rtl/adc_depth_scanner.sv
// Round-robin scanner for an 8-channel 12-bit serial ADC with depth-channel averaging.
module adc_depth_scanner
    import adc_pkg::*;
#(
    parameter int unsigned CLK_DIV    = 25,
    parameter int unsigned NUM_CH     = 8,
    parameter int unsigned DEPTH_CH   = 0,
    parameter int unsigned AVG_LOG2   = 4,
    parameter int unsigned GAP_CYCLES = 4
) (
    input  logic                sys_clk,
    input  logic                reset,
    input  logic                enable,
    output logic                ADC_CS_N,
    output logic                ADC_SCLK,
    output logic                ADC_SADDR,
    input  logic                ADC_SDAT,
    output logic                sample_valid,
    output logic [2:0]          sample_ch,
    output logic [ADC_BITS-1:0] sample_data,
    output logic [31:0]         raw_depth,
    output logic                depth_valid
);

    localparam int unsigned GapW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    scan_state_e          state_q, state_d;
    sclk_phase_e          phase_q;
    logic [7:0]           div_cnt_q;
    logic [GapW-1:0]      gap_cnt_q;
    logic [BIT_CNT_W-1:0] bit_cnt_q;
    // Only the low 12 bits of a frame matter; the four leading zeros shift through and drop out.
    logic [ADC_BITS-1:0]  shreg_q;
    logic [2:0]           addr_ch_q;
    logic [2:0]           prev_ch_q;
    logic                 first_frame_q;
    logic                 cs_n_q;
    logic                 sclk_q;
    logic                 saddr_q;
    logic                 sample_valid_q;
    logic [2:0]           sample_ch_q;
    logic [ADC_BITS-1:0]  sample_data_q;

    logic tick;
    logic gap_load;
    logic gap_done;
    logic frame_done;

    assign tick       = (state_q == StShift) && (div_cnt_q == 8'(CLK_DIV - 1));
    assign gap_done   = (state_q == StGap) && (gap_cnt_q == '0);
    assign frame_done = tick && (phase_q == PhHighPending) &&
                        (bit_cnt_q == BIT_CNT_W'(FRAME_BITS - 1));

    always_comb begin
        state_d  = state_q;
        gap_load = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (enable) begin
                    state_d  = StGap;
                    gap_load = 1'b1;
                end
            end
            StGap: begin
                if (gap_done) state_d = StShift;
            end
            StShift: begin
                if (frame_done) state_d = StStore;
            end
            StStore: begin
                // enable is only honoured here and in idle, so a frame is never cut short.
                if (enable) begin
                    state_d  = StGap;
                    gap_load = 1'b1;
                end else begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            phase_q        <= PhLowPending;
            div_cnt_q      <= '0;
            gap_cnt_q      <= '0;
            bit_cnt_q      <= '0;
            shreg_q        <= '0;
            addr_ch_q      <= '0;
            prev_ch_q      <= '0;
            first_frame_q  <= 1'b1;
            cs_n_q         <= 1'b1;
            sclk_q         <= 1'b1;
            saddr_q        <= 1'b0;
            sample_valid_q <= 1'b0;
            sample_ch_q    <= '0;
            sample_data_q  <= '0;
        end else begin
            sample_valid_q <= 1'b0;
            div_cnt_q      <= ((state_q == StShift) && !tick) ? div_cnt_q + 8'd1 : 8'd0;

            if (gap_load) begin
                gap_cnt_q <= GapW'(GAP_CYCLES - 1);
            end else if ((state_q == StGap) && (gap_cnt_q != '0)) begin
                gap_cnt_q <= gap_cnt_q - 1'b1;
            end

            if (gap_done) begin
                cs_n_q    <= 1'b0;
                bit_cnt_q <= '0;
                phase_q   <= PhLowPending;
            end

            if (tick) begin
                if (phase_q == PhLowPending) begin
                    sclk_q  <= 1'b0;
                    saddr_q <= addr_bit(addr_ch_q, bit_cnt_q);
                    phase_q <= PhHighPending;
                end else begin
                    // Rising SCLK is the sample point for DOUT.
                    sclk_q    <= 1'b1;
                    shreg_q   <= {shreg_q[ADC_BITS-2:0], ADC_SDAT};
                    bit_cnt_q <= bit_cnt_q + 1'b1;
                    phase_q   <= PhLowPending;
                    if (frame_done) cs_n_q <= 1'b1;
                end
            end

            if (state_q == StStore) begin
                // The ADC answers one frame late, so the data belongs to the previous address.
                if (!first_frame_q) begin
                    sample_valid_q <= 1'b1;
                    sample_ch_q    <= prev_ch_q;
                    sample_data_q  <= shreg_q;
                end
                first_frame_q <= 1'b0;
                prev_ch_q     <= addr_ch_q;
                addr_ch_q     <= (addr_ch_q == 3'(NUM_CH - 1)) ? 3'd0 : addr_ch_q + 3'd1;
            end
        end
    end

    assign ADC_CS_N     = cs_n_q;
    assign ADC_SCLK     = sclk_q;
    assign ADC_SADDR    = saddr_q;
    assign sample_valid = sample_valid_q;
    assign sample_ch    = sample_ch_q;
    assign sample_data  = sample_data_q;

    depth_averager #(
        .DEPTH_CH (DEPTH_CH),
        .AVG_LOG2 (AVG_LOG2)
    ) u_depth_averager (
        .sys_clk      (sys_clk),
        .reset        (reset),
        .sample_valid (sample_valid_q),
        .sample_ch    (sample_ch_q),
        .sample_data  (sample_data_q),
        .raw_depth    (raw_depth),
        .depth_valid  (depth_valid)
    );

endmodule

// File: tb/tb_adc_depth_scanner.sv
// Bench for adc_depth_scanner: pin-level ADC model, strobe scoreboard and depth-average model.
module tb_adc_depth_scanner;

    localparam int unsigned CLK_DIV    = 4;
    localparam int unsigned NUM_CH     = 8;
    localparam int unsigned DEPTH_CH   = 0;
    localparam int unsigned AVG_LOG2   = 4;
    localparam int unsigned GAP_CYCLES = 4;
    localparam int unsigned FRAME_CYC  = 32 * CLK_DIV;
    localparam int unsigned PERIOD_CYC = 32 * CLK_DIV + GAP_CYCLES + 1;

    logic        sys_clk = 1'b0;
    logic        reset   = 1'b1;
    logic        enable  = 1'b0;
    logic        ADC_CS_N, ADC_SCLK, ADC_SADDR;
    logic        sdat = 1'b0;
    logic        sample_valid;
    logic [2:0]  sample_ch;
    logic [11:0] sample_data;
    logic [31:0] raw_depth;
    logic        depth_valid;

    int vectors     = 0;
    int miscompares = 0;
    int mode        = 0;  // 0: ch k -> 0x100+k, 1: ch0 ramps 0,1,2.., 2: ch0 = 0xFFF
    int stim_epoch  = 0;

    always #5 sys_clk = ~sys_clk;

    adc_depth_scanner #(
        .CLK_DIV    (CLK_DIV),
        .NUM_CH     (NUM_CH),
        .DEPTH_CH   (DEPTH_CH),
        .AVG_LOG2   (AVG_LOG2),
        .GAP_CYCLES (GAP_CYCLES)
    ) dut (
        .sys_clk      (sys_clk),
        .reset        (reset),
        .enable       (enable),
        .ADC_CS_N     (ADC_CS_N),
        .ADC_SCLK     (ADC_SCLK),
        .ADC_SADDR    (ADC_SADDR),
        .ADC_SDAT     (sdat),
        .sample_valid (sample_valid),
        .sample_ch    (sample_ch),
        .sample_data  (sample_data),
        .raw_depth    (raw_depth),
        .depth_valid  (depth_valid)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- ADC model + scoreboard, sampled on the falling sys_clk edge ----------------
    typedef struct {
        logic [2:0]  ch;
        logic [11:0] data;
    } samp_t;

    samp_t       exp_q[$];
    logic        cs_prev = 1'b1, sclk_prev = 1'b1;
    int          rises = 0, falls = 0, cs_low_cyc = 0, saddr_bad = 0;
    logic [15:0] word = '0;
    logic [2:0]  addr_reg = '0, new_addr = '0, ret_ch = '0, exp_addr = '0;
    bit          discard = 1'b1, dv_due = 1'b0;
    int          pend_age = 0, acc_m = 0, n_m = 0, seq = 0, last_mode = 0;
    logic [31:0] exp_depth = '0;
    int          cyc = 0, last_strobe = -1, last_epoch = 0;

    always @(negedge sys_clk) begin
        samp_t       s;
        logic [11:0] v;
        cyc++;
        if (reset) begin
            exp_q.delete();
            discard     = 1'b1;
            exp_addr    = '0;
            acc_m       = 0;
            n_m         = 0;
            exp_depth   = '0;
            dv_due      = 1'b0;
            pend_age    = 0;
            last_strobe = -1;
            cs_prev     = 1'b1;
            sclk_prev   = 1'b1;
            rises       = 0;
        end else begin
            if (mode != last_mode) begin
                seq       = 0;
                last_mode = mode;
            end

            check("depth_valid", depth_valid, dv_due);
            check("raw_depth", raw_depth, exp_depth);
            dv_due = 1'b0;

            if (sample_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_strobe", sample_valid, 0);
                end else begin
                    s = exp_q.pop_front();
                    check("sample_ch", sample_ch, s.ch);
                    check("sample_data", sample_data, s.data);
                    if (s.ch == 3'(DEPTH_CH)) begin
                        acc_m += int'(s.data);
                        n_m++;
                        if (n_m == (1 << AVG_LOG2)) begin
                            exp_depth = 32'(acc_m / (1 << AVG_LOG2));
                            acc_m     = 0;
                            n_m       = 0;
                            dv_due    = 1'b1;
                        end
                    end
                end
                if (last_strobe >= 0 && last_epoch == stim_epoch) begin
                    check("strobe_spacing", 64'(cyc - last_strobe), PERIOD_CYC);
                end
                last_strobe = cyc;
                last_epoch  = stim_epoch;
                pend_age    = 0;
            end else if (exp_q.size() != 0) begin
                pend_age++;
                if (pend_age > 4) begin
                    check("missing_strobe", sample_valid, 1);
                    exp_q.delete();
                    pend_age = 0;
                end
            end

            // ADC pins: frame start returns the conversion for the previously latched address.
            if (cs_prev && !ADC_CS_N) begin
                rises      = 0;
                falls      = 0;
                cs_low_cyc = 0;
                saddr_bad  = 0;
                new_addr   = '0;
                ret_ch     = addr_reg;
                if (mode == 1 && addr_reg == 3'd0) begin
                    v = discard ? 12'h000 : 12'(seq);
                    if (!discard) seq++;
                end else if (mode == 2 && addr_reg == 3'd0) begin
                    v = 12'hFFF;
                end else begin
                    v = 12'h100 + 12'(addr_reg);
                end
                word = {4'h0, v};
            end
            if (!ADC_CS_N) cs_low_cyc++;
            if (!cs_prev && sclk_prev && !ADC_SCLK) begin
                if (falls < 16) sdat = word[4'(15 - falls)];
                falls++;
            end
            if (!cs_prev && !sclk_prev && ADC_SCLK) begin
                if (rises >= 2 && rises <= 4) new_addr = {new_addr[1:0], ADC_SADDR};
                else if (ADC_SADDR) saddr_bad++;
                rises++;
            end
            if (!cs_prev && ADC_CS_N) begin
                check("sclk_falls", falls, 16);
                check("cs_low_cycles", cs_low_cyc, FRAME_CYC);
                check("saddr_channel", new_addr, exp_addr);
                check("saddr_zero_bits", saddr_bad, 0);
                exp_addr = (exp_addr == 3'(NUM_CH - 1)) ? 3'd0 : exp_addr + 3'd1;
                addr_reg = new_addr;
                if (!discard) exp_q.push_back('{ch: ret_ch, data: word[11:0]});
                discard = 1'b0;
            end
            cs_prev   = ADC_CS_N;
            sclk_prev = ADC_SCLK;
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic wait_strobe(input string name);
        int t;
        t = 0;
        do begin
            @(negedge sys_clk);
            t++;
        end while (!sample_valid && t < 3 * PERIOD_CYC);
        if (!sample_valid) check(name, sample_valid, 1);
    endtask

    task automatic wait_depth(input string name, input int frames);
        int t;
        t = 0;
        do begin
            @(negedge sys_clk);
            t++;
        end while (!depth_valid && t < frames * PERIOD_CYC);
        if (!depth_valid) check(name, depth_valid, 1);
    endtask

    // Returns once n falling SCLK edges of the next frame have been seen.
    task automatic wait_bit(input int n);
        int   t, f;
        logic sp;
        t = 0;
        f = 0;
        while (ADC_CS_N === 1'b1 && t < 2 * PERIOD_CYC) begin
            @(negedge sys_clk);
            t++;
        end
        sp = ADC_SCLK;
        while (f < n && t < 4 * PERIOD_CYC) begin
            @(negedge sys_clk);
            t++;
            if (sp && !ADC_SCLK) f++;
            sp = ADC_SCLK;
        end
        if (f < n) check("wait_bit_timeout", f, n);
    endtask

    initial begin
        int cs_low;

        repeat (3) @(posedge sys_clk);
        @(negedge sys_clk);
        check("rst_cs_n", ADC_CS_N, 1);
        check("rst_sclk", ADC_SCLK, 1);
        check("rst_saddr", ADC_SADDR, 0);
        check("rst_sample_valid", sample_valid, 0);
        check("rst_sample_ch", sample_ch, 0);
        check("rst_sample_data", sample_data, 0);
        check("rst_raw_depth", raw_depth, 0);
        check("rst_depth_valid", depth_valid, 0);

        // Round-robin scan: first frame discarded, then ch0..ch7, then wrap.
        @(posedge sys_clk);
        #1 reset = 1'b0;
        enable = 1'b1;
        wait_strobe("first_strobe_timeout");
        check("first_strobe_ch", sample_ch, 0);
        check("first_strobe_data", sample_data, 12'h100);
        for (int i = 1; i < 8; i++) wait_strobe("scan_strobe_timeout");
        check("ch7_data", sample_data, 12'h107);
        wait_strobe("wrap_strobe_timeout");
        check("wrap_ch", sample_ch, 0);
        check("wrap_data", sample_data, 12'h100);

        // Drop enable mid-frame: that frame still completes, then the scanner stays idle.
        wait_bit(8);
        enable = 1'b0;
        wait_strobe("drain_strobe_timeout");
        cs_low = 0;
        repeat (3 * PERIOD_CYC) begin
            @(negedge sys_clk);
            if (!ADC_CS_N) cs_low++;
        end
        check("idle_cs_low_cycles", cs_low, 0);
        stim_epoch++;
        enable = 1'b1;
        for (int i = 0; i < 3; i++) wait_strobe("resume_strobe_timeout");

        // Reset in bit 9 of a frame; outputs clear at once without a clock edge.
        wait_bit(10);
        @(posedge sys_clk);
        #3 reset = 1'b1;
        mode = 1;
        stim_epoch++;
        #1;
        check("async_cs_n", ADC_CS_N, 1);
        check("async_sclk", ADC_SCLK, 1);
        check("async_sample_data", sample_data, 0);
        check("async_sample_ch", sample_ch, 0);
        repeat (2) @(posedge sys_clk);
        #1 reset = 1'b0;

        // Ramp 0..15 on the depth channel: mean 7.
        wait_depth("ramp_depth_timeout", 140);
        check("ramp_raw_depth", raw_depth, 32'h0000_0007);
        mode = 2;

        // Full-scale input must average without overflow.
        wait_depth("fullscale_depth_timeout", 140);
        check("fullscale_raw_depth", raw_depth, 32'h0000_0FFF);

        repeat (4) @(negedge sys_clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
